// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Brief    : Shared types and default widths for sync_fifo_wr_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Default-configuration widths (NUM_REQ = 4, ADDR_WIDTH = 3).
    localparam int IDX_W = $clog2(4);
    localparam int CNT_W = 3 + 1;

    // Arbiter FSM states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin picker. Searches i_req starting at
//             (i_ptr + 1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0, and returns
//             a one-hot grant plus its index (zero when nothing requests).
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic [NUM_REQ-1:0] w_above;   // positions strictly after the pointer
    logic [NUM_REQ-1:0] w_cand;

    // Mark every position that comes after the pointer in search order.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_above
            localparam logic [IDX_W:0] c_POS = (IDX_W+1)'(gi);
            assign w_above[gi] = c_POS > {1'b0, i_ptr};
        end
    endgenerate

    // Prefer requesters after the pointer; otherwise wrap to the lowest index.
    always_comb begin
        w_cand    = ((i_req & w_above) != '0) ? (i_req & w_above) : i_req;
        o_gnt     = '0;
        o_gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                o_gnt     = '0;
                o_gnt[i]  = 1'b1;
                o_gnt_idx = i[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/sync_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_wr_arbiter
//  Brief    : Round-robin write arbiter sharing one sync FIFO write port among
//             NUM_REQ producers. Registered wr_en/wr_data; flow control uses
//             FIFO occupancy plus the in-flight write so the FIFO never
//             overflows.
//  Config   : FIFO_ARB_BURST_EN - when defined, a granted producer keeps the
//             port for up to MAX_BURST contiguous beats (HOLD state).
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [ADDR_WIDTH:0]           fifo_cnt,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_SPC_W = ADDR_WIDTH + 2;

    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [c_IDX_W-1:0]    r_grant_id;
    logic [c_IDX_W-1:0]    r_rr_ptr;

    logic [c_SPC_W-1:0]    w_occ;
    logic                  w_space;
    logic [NUM_REQ-1:0]    w_rr_gnt;
    logic [c_IDX_W-1:0]    w_rr_idx;
    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [c_IDX_W-1:0]    w_pick_idx;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_beat [NUM_REQ];

    // Occupancy including the write already registered but not yet in the FIFO.
    assign w_occ   = {1'b0, fifo_cnt} + {{(c_SPC_W-1){1'b0}}, r_wr_en};
    assign w_space = w_occ < c_SPC_W'(FIFO_DEPTH);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_rr_gnt),
        .o_gnt_idx (w_rr_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_beat[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

`ifdef FIFO_ARB_BURST_EN
    localparam int         c_BCNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [0:0] c_ST_IDLE = IDLE;
    localparam logic [0:0] c_ST_HOLD = HOLD;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_BCNT_W-1:0] r_burst_cnt;
    logic [c_BCNT_W-1:0] w_bcnt_nxt;
    logic [c_BCNT_W-1:0] w_bcnt_inc;
    logic                w_hold_act;

    // The lock only matters while the holder still has data; once it drops
    // valid, ordinary round-robin takes over in the same cycle.
    assign w_hold_act = (r_state == c_ST_HOLD) && req_valid[r_rr_ptr];
    assign w_pick_gnt = w_hold_act ? (NUM_REQ'(1) << r_rr_ptr) : w_rr_gnt;
    assign w_pick_idx = w_hold_act ? r_rr_ptr : w_rr_idx;
    assign w_bcnt_inc = r_burst_cnt + c_BCNT_W'(1);

    // Burst FSM next state: count held beats, release after MAX_BURST.
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_burst_cnt;
        if (w_accept) begin
            if (w_hold_act) begin
                if (w_bcnt_inc == c_BCNT_W'(MAX_BURST)) begin
                    w_state_nxt = c_ST_IDLE;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_bcnt_nxt  = w_bcnt_inc;
                end
            end else if (MAX_BURST > 1) begin
                w_state_nxt = c_ST_HOLD;
                w_bcnt_nxt  = c_BCNT_W'(1);
            end else begin
                w_state_nxt = c_ST_IDLE;
                w_bcnt_nxt  = '0;
            end
        end else if (!w_hold_act) begin
            w_state_nxt = c_ST_IDLE;
            w_bcnt_nxt  = '0;
        end
    end

    // Burst FSM state and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_bcnt_nxt;
        end
    end
`else
    assign w_pick_gnt = w_rr_gnt;
    assign w_pick_idx = w_rr_idx;
`endif

    assign w_ready   = {NUM_REQ{w_space}} & w_pick_gnt;
    assign w_accept  = |w_ready;
    assign req_ready = w_ready & {NUM_REQ{rst_n}};

    // Register the accepted beat toward the FIFO and advance the rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= c_IDX_W'(NUM_REQ - 1);
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_data  <= w_beat[w_pick_idx];
                r_grant_id <= w_pick_idx;
                r_rr_ptr   <= w_pick_idx;
            end
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_data  = r_wr_data;
    assign grant_id = r_grant_id;

endmodule : sync_fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_sync_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_wr_arbiter
//  Brief    : Self-checking bench for sync_fifo_wr_arbiter: a beat-level model
//             checked every cycle plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int NR    = 4;
    localparam int MB    = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [AW:0]     fifo_cnt;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    sync_fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_cnt  (fifo_cnt),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Beat-level model: who may send this cycle, and what the write port shows.
    int        m_ptr;
    bit        m_wr_en;
    logic [7:0] m_data;
    int        m_gid;
    bit        m_burst;   // a producer currently owns a burst
    int        m_beats;   // beats already sent in that burst

    always @(negedge clk) begin : p_compare
        int         pick;
        int         idx;
        bit         space;
        bit         holder_on;
        logic [3:0] er;
        if (!rst_n) begin
            m_ptr = NR - 1; m_wr_en = 0; m_data = '0; m_gid = 0; m_burst = 0; m_beats = 0;
            chk("rst_ready", req_ready, 0);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_grant", grant_id, 0);
        end else begin
            space     = (int'(fifo_cnt) + int'(m_wr_en)) < DEPTH;
            holder_on = m_burst && req_valid[m_ptr];
            pick = -1;
            if (holder_on) pick = m_ptr;
            else begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (pick < 0 && req_valid[idx]) pick = idx;
                end
            end
            er = (space && pick >= 0) ? 4'(1 << pick) : 4'b0000;
            chk("model_ready", req_ready, er);
            chk("model_wr_en", wr_en, m_wr_en);
            chk("model_wr_data", wr_data, m_data);
            chk("model_grant", grant_id, m_gid);
            if (er != 0) begin
                if (holder_on) begin
                    m_beats++;
                    if (m_beats == MB) begin m_burst = 0; m_beats = 0; end
                end else begin
                    m_beats = 1;
                    m_burst = BURST_ON && (MB > 1);
                end
                m_wr_en = 1; m_data = req_data[pick*DW +: DW]; m_gid = pick; m_ptr = pick;
            end else begin
                m_wr_en = 0;
                if (!holder_on) begin m_burst = 0; m_beats = 0; end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    logic [3:0] exp_seq [8];
    logic [1:0] exp_gid [8];

    initial begin
        rst_n = 1'b0; req_valid = 4'hF; fifo_cnt = '0; req_data = 32'h4433_2211;
        #2;
        chk("t1_rst_ready", req_ready, 0);
        chk("t1_rst_wr_en", wr_en, 0);
        cyc(); cyc();
`ifndef FIFO_ARB_BURST_EN
        // Strict round-robin over four always-valid producers.
        exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        exp_gid = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        rst_n = 1'b1;
`else
        // Bursts of four from producer 0, then four from producer 1.
        exp_seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
        exp_gid = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        req_valid = 4'b0011;
        rst_n = 1'b1;
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_seq_ready", req_ready, exp_seq[i]);
            if (i > 0) begin
                chk("t2_seq_wr_en", wr_en, 1);
                chk("t2_seq_grant", grant_id, exp_gid[i]);
            end
        end
`ifdef FIFO_ARB_BURST_EN
        // Holder drops valid after two beats: producer 1 is served at once.
        cyc(); rst_n = 1'b0; cyc(); rst_n = 1'b1; req_valid = 4'b0011;
        cyc(); cyc(); req_valid = 4'b0010;
        @(negedge clk);
        chk("t5_drop_ready", req_ready, 4'b0010);
`endif
        // Backpressure around the full boundary.
        cyc(); req_valid = '0; cyc(); cyc();
        req_data = 32'h8877_6655; req_valid = 4'b0001; fifo_cnt = 4'd7;
        @(negedge clk); chk("t3_cnt7_ready", req_ready, 4'b0001);
        cyc();
        @(negedge clk); chk("t3_inflight_ready", req_ready, 0);
        chk("t3_inflight_wr_en", wr_en, 1);
        chk("t3_inflight_data", wr_data, 8'h55);
        cyc(); fifo_cnt = 4'd8;
        @(negedge clk); chk("t3_full_ready", req_ready, 0);
        cyc(); fifo_cnt = 4'd6;
        @(negedge clk); chk("t3_resume_ready", req_ready, 4'b0001);

        // Wrap: pointer at 3, producers 1 and 2 valid -> 1 wins.
        cyc(); req_valid = '0; fifo_cnt = '0;
        cyc(); req_valid = 4'b1000; req_data = 32'hDDCC_BBAA;
        cyc(); req_valid = 4'b0110;
        @(negedge clk); chk("t4_wrap_ready", req_ready, 4'b0010);
        chk("t4_wrap_prev_grant", grant_id, 3);
        cyc();
        @(negedge clk); chk("t4_wrap_data", wr_data, 8'hBB);
        chk("t4_wrap_grant", grant_id, 1);

        // Asynchronous reset right after the second beat.
        cyc(); req_valid = '0;
        cyc(); req_valid = 4'b0011; req_data = 32'h0000_2F1E;
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_async_wr_en", wr_en, 0);
        chk("t6_async_data", wr_data, 0);
        chk("t6_async_grant", grant_id, 0);
        chk("t6_async_ready", req_ready, 0);
        cyc(); rst_n = 1'b1;
        @(negedge clk); chk("t6_restart_ready", req_ready, 4'b0001);
        cyc();
        @(negedge clk); chk("t6_restart_grant", grant_id, 0);
        chk("t6_restart_data", wr_data, 8'h1E);

        cyc(); req_valid = '0; cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sync_fifo_wr_arbiter
`default_nettype wire
